// File: rtl/slicer_axil_pkg.sv
// Shared constants and FSM state types for the slicer AXI4-Lite core.
package slicer_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_OFFSET = 1;
  localparam int unsigned REG_WIDTH  = 2;
  localparam int unsigned REG_STATUS = 3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_CLR_BIT  = 1;
  localparam int unsigned CTRL_SIGN_BIT = 2;

  typedef enum logic [1:0] {WrIdle, WrWaitW, WrWaitAw, WrResp} wr_state_t;
  typedef enum logic {RdIdle, RdResp} rd_state_t;

endpackage

// File: rtl/slicer_field_extract.sv
// Registered bit-field extractor: shift, mask and optional sign-extend, 1-cycle latency.
module slicer_field_extract #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sample_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] offset_i,
  input  logic [$clog2(DATA_WIDTH):0]   width_i,
  input  logic                          sign_en_i,
  output logic [DATA_WIDTH-1:0]         dout_o,
  output logic                          dout_valid_o
);

  localparam int unsigned OffW = $clog2(DATA_WIDTH);
  localparam logic [OffW:0] DwL = DATA_WIDTH[OffW:0];

  logic [DATA_WIDTH-1:0] shifted, mask, field_d, dout_q;
  logic [OffW-1:0]       msb_sel;
  logic                  sign_bit, extend, dout_valid_q;

  always_comb begin
    // Logical shift zero-fills anything that would come from above the word.
    shifted = din_i >> offset_i;
    if (width_i >= DwL) begin
      mask = '1;
    end else begin
      mask = (DATA_WIDTH'(1) << width_i) - DATA_WIDTH'(1);
    end
    msb_sel  = width_i[OffW-1:0] - OffW'(1);
    sign_bit = shifted[msb_sel];
    extend   = sign_en_i && (width_i != '0) && (width_i < DwL) && sign_bit;
    field_d  = (shifted & mask) | (extend ? ~mask : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= sample_i;
      if (sample_i) begin
        dout_q <= field_d;
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;

endmodule

// File: rtl/slicer_axil_core.sv
// AXI4-Lite register slave driving a streaming bit-field slicer.
// Define SLICER_SIGN_EXT_EN to add CTRL bit2 (sign_en) for sign-extended output fields.
module slicer_axil_core
  import slicer_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]              s00_axi_awprot,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]              s00_axi_arprot,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
  localparam int unsigned OffW    = $clog2(DATA_WIDTH);
  localparam logic [IdxW:0] NumRegsL = NUM_REGS[IdxW:0];

`ifdef SLICER_SIGN_EXT_EN
  localparam logic [DATA_WIDTH-1:0] CtrlMask =
      DATA_WIDTH'((1 << CTRL_EN_BIT) | (1 << CTRL_SIGN_BIT));
`else
  localparam logic [DATA_WIDTH-1:0] CtrlMask = DATA_WIDTH'(1 << CTRL_EN_BIT);
`endif

  logic clk, rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  wr_state_t             wr_state_q, wr_state_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, w_data_q, cnt_q;
  logic [StrbW-1:0]      w_strb_q, wr_strb;
  logic [IdxW-1:0]       aw_idx_q, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged, rd_word;
  logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_in_range, rd_in_range;
  logic                  sample, cnt_clr, sign_en;
  logic                  unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[AddrLsb-1:0], s00_axi_araddr[AddrLsb-1:0]};

  assign aw_hs = s00_axi_awvalid & awready_q;
  assign w_hs  = s00_axi_wvalid & wready_q;
  assign ar_hs = s00_axi_arvalid & arready_q;

  // Address/data come live from the bus unless that half was captured earlier.
  always_comb begin
    wr_idx  = (wr_state_q == WrWaitW) ? aw_idx_q : s00_axi_awaddr[ADDR_WIDTH-1:AddrLsb];
    wr_data = (wr_state_q == WrWaitAw) ? w_data_q : s00_axi_wdata;
    wr_strb = (wr_state_q == WrWaitAw) ? w_strb_q : s00_axi_wstrb;
    wr_in_range = ({1'b0, wr_idx} < NumRegsL);
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IdxW'(i)) wr_old = regs_q[i];
    end
    wr_merged = wr_old;
    for (int b = 0; b < StrbW; b++) begin
      if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_idx      = s00_axi_araddr[ADDR_WIDTH-1:AddrLsb];
    rd_in_range = ({1'b0, rd_idx} < NumRegsL);
    rd_word     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IdxW'(i)) rd_word = regs_q[i];
    end
    if (rd_idx == IdxW'(REG_STATUS)) rd_word = cnt_q;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_fire    = 1'b0;
    case (wr_state_q)
      WrIdle: begin
        if (aw_hs && w_hs) begin
          wr_state_d = WrResp;
          wr_fire    = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = WrWaitW;
        end else if (w_hs) begin
          wr_state_d = WrWaitAw;
        end
      end
      WrWaitW: if (w_hs) begin
        wr_state_d = WrResp;
        wr_fire    = 1'b1;
      end
      WrWaitAw: if (aw_hs) begin
        wr_state_d = WrResp;
        wr_fire    = 1'b1;
      end
      WrResp: if (s00_axi_bready) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RdIdle:  if (ar_hs) rd_state_d = RdResp;
      RdResp:  if (s00_axi_rready) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  // Ready flags are registered from the next state, so they sit low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WrIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= (wr_state_d == WrIdle) || (wr_state_d == WrWaitAw);
      wready_q   <= (wr_state_d == WrIdle) || (wr_state_d == WrWaitW);
      if (aw_hs) aw_idx_q <= s00_axi_awaddr[ADDR_WIDTH-1:AddrLsb];
      if (w_hs) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= (rd_state_d == RdIdle);
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_in_range ? rd_word : '0;
        rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // STATUS slot is never written; reads of it are served from the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire && wr_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IdxW'(i) && i != REG_STATUS) begin
          regs_q[i] <= (i == REG_CTRL) ? (wr_merged & CtrlMask) : wr_merged;
        end
      end
    end
  end

  assign sample  = regs_q[REG_CTRL][CTRL_EN_BIT] & din_valid;
  assign cnt_clr = wr_fire & wr_in_range & (wr_idx == IdxW'(REG_CTRL)) & wr_strb[0] &
                   wr_data[CTRL_CLR_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (sample) begin
      cnt_q <= cnt_q + DATA_WIDTH'(1);
    end
  end

`ifdef SLICER_SIGN_EXT_EN
  assign sign_en = regs_q[REG_CTRL][CTRL_SIGN_BIT];
`else
  assign sign_en = 1'b0;
`endif

  slicer_field_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extract (
    .clk_i        (clk),
    .rst_i        (rst),
    .sample_i     (sample),
    .din_i        (din),
    .offset_i     (regs_q[REG_OFFSET][OffW-1:0]),
    .width_i      (regs_q[REG_WIDTH][OffW:0]),
    .sign_en_i    (sign_en),
    .dout_o       (dout),
    .dout_valid_o (dout_valid)
  );

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_slicer_axil_core.sv
// Directed self-checking bench for slicer_axil_core (default 32/6/8 configuration).
module tb_slicer_axil_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, din, dout;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        din_valid, dout_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  slicer_axil_core #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .NUM_REGS   (8)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .din             (din),
    .din_valid       (din_valid),
    .dout            (dout),
    .dout_valid      (dout_valid)
  );

  // Bus tasks are entered and left on a falling edge.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_acc, w_acc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(negedge clk);
      if (aw_acc) awvalid = 0;
      if (w_acc) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_bvalid addr=%h: got %b expected 1", a, bvalid);
    end
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_rvalid addr=%h: got %b expected 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic drive_sample(input logic [31:0] d);
    din = d; din_valid = 1;
    @(negedge clk);
    din_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0; din = 0; din_valid = 0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, dout_valid} !== 6'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/val=%b dout=%h expected 000000 and 0",
               {awready, wready, arready, bvalid, rvalid, dout_valid}, dout);
    end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_regmap();
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] exp_val [8] = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h5, 32'h6, 32'h7, 32'h8};
    for (int i = 0; i < 8; i++) begin
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, resp);
      n_checks++;
      if (resp !== 2'b00) begin
        n_fail++;
        $display("FAIL regmap_bresp idx=%0d: got %b expected 00", i, resp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      axi_read(6'(i * 4), rd, resp);
      n_checks++;
      if (rd !== exp_val[i] || resp !== 2'b00) begin
        n_fail++;
        $display("FAIL regmap_read idx=%0d: got %h/%b expected %h/00", i, rd, resp, exp_val[i]);
      end
    end
  endtask

  task automatic test_strobe_order();
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        bv_early;
    axi_write(6'h14, 32'h0, 4'hF, resp);
    wdata = 32'hAABBCCDD; wstrb = 4'b0010; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0;
    n_checks++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_aw_ready: got w=%b aw=%b expected 0 1", wready, awready);
    end
    @(negedge clk);
    awaddr = 6'h14; awvalid = 1;
    bv_early = bvalid;
    @(negedge clk);
    awvalid = 0;
    n_checks++;
    if (bv_early !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL w_first_bvalid: got before=%b after=%b resp=%b expected 0 1 00",
               bv_early, bvalid, bresp);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    axi_read(6'h14, rd, resp);
    n_checks++;
    if (rd !== 32'h0000CC00) begin
      n_fail++;
      $display("FAIL strobe_data: got %h expected 0000cc00", rd);
    end
  endtask

  task automatic test_slverr();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h20, 32'h12345678, 4'hF, resp);
    n_checks++;
    if (resp !== 2'b10) begin
      n_fail++;
      $display("FAIL slverr_bresp: got %b expected 10", resp);
    end
    axi_read(6'h3C, rd, resp);
    n_checks++;
    if (resp !== 2'b10 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL slverr_read: got %h/%b expected 00000000/10", rd, resp);
    end
  endtask

  task automatic test_slicer();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h00, 32'h1, 4'hF, resp);
    axi_write(6'h04, 32'd8, 4'hF, resp);
    axi_write(6'h08, 32'd4, 4'hF, resp);
    drive_sample(32'h0000_0A50);
    n_checks++;
    if (dout !== 32'hA || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL slice_8_4: got %h/%b expected 0000000a/1", dout, dout_valid);
    end
    @(negedge clk);
    n_checks++;
    if (dout !== 32'hA || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL slice_hold: got %h/%b expected 0000000a/0", dout, dout_valid);
    end
    axi_write(6'h04, 32'd30, 4'hF, resp);
    axi_write(6'h08, 32'd8, 4'hF, resp);
    drive_sample(32'hC000_0000);
    n_checks++;
    if (dout !== 32'h3) begin
      n_fail++;
      $display("FAIL slice_zero_fill: got %h expected 00000003", dout);
    end
    axi_write(6'h08, 32'd0, 4'hF, resp);
    drive_sample(32'hFFFF_FFFF);
    n_checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL slice_width0: got %h/%b expected 00000000/1", dout, dout_valid);
    end
    axi_write(6'h04, 32'd4, 4'hF, resp);
    axi_write(6'h08, 32'd40, 4'hF, resp);
    drive_sample(32'h1234_5678);
    n_checks++;
    if (dout !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL slice_wide_mask: got %h expected 01234567", dout);
    end
    axi_write(6'h04, 32'd0, 4'hF, resp);
    axi_write(6'h08, 32'd4, 4'hF, resp);
    axi_write(6'h00, 32'h5, 4'hF, resp);
    axi_read(6'h00, rd, resp);
    drive_sample(32'h0000_000C);
`ifdef SLICER_SIGN_EXT_EN
    n_checks++;
    if (rd !== 32'h5 || dout !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL sign_ext_on: got ctrl=%h dout=%h expected 5 fffffffc", rd, dout);
    end
    axi_write(6'h00, 32'h1, 4'hF, resp);
    drive_sample(32'h0000_000C);
    n_checks++;
    if (dout !== 32'hC) begin
      n_fail++;
      $display("FAIL sign_ext_off: got %h expected 0000000c", dout);
    end
`else
    n_checks++;
    if (rd !== 32'h1 || dout !== 32'hC) begin
      n_fail++;
      $display("FAIL zero_ext_only: got ctrl=%h dout=%h expected 1 0000000c", rd, dout);
    end
`endif
  endtask

  task automatic test_status();
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        held;
    axi_write(6'h00, 32'h3, 4'hF, resp);
    din = 32'h55; din_valid = 1;
    repeat (5) @(negedge clk);
    din_valid = 0;
    axi_read(6'h0C, rd, resp);
    n_checks++;
    if (rd !== 32'd5) begin
      n_fail++;
      $display("FAIL status_count: got %0d expected 5", rd);
    end
    awaddr = 6'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    din_valid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; din_valid = 0;
    held = 1;
    repeat (10) begin
      held = held & (bvalid === 1'b1) & (awready === 1'b0);
      @(negedge clk);
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL bready_stall: got held=%b expected 1", held);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    axi_read(6'h0C, rd, resp);
    n_checks++;
    if (rd !== 32'd0 || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL status_clr_wins: got %0d/%b expected 0/00", rd, resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  resp;
    logic [31:0] rd;
    awaddr = 6'h18; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h18; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_checks++;
    if (rdata !== 32'h7 || rvalid !== 1'b1 || bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_rw: got rdata=%h rv=%b bv=%b expected 00000007 1 1",
               rdata, rvalid, bvalid);
    end
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(6'h18, rd, resp);
    n_checks++;
    if (rd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rw_new_value: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0]  resp;
    logic [31:0] rd;
    awaddr = 6'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h10; arvalid = 1; bready = 0; rready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_resp: got bv=%b rv=%b expected 1 1", bvalid, rvalid);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got bv=%b rv=%b awr=%b dout=%h expected 0 0 0 0",
               bvalid, rvalid, awready, dout);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    axi_read(6'h10, rd, resp);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clears_reg: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_strobe_order();
    test_slverr();
    test_slicer();
    test_status();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
